// File: rtl/stutter_scheduler_if.sv
// Harness <-> scheduler bundle: observation/termination in, stutter
// commands and status out. master = harness, slave = scheduler.
interface stutter_scheduler_if #(
  parameter int SYNC_W = 4,
  parameter int STAT_W = 8
);
  logic              obs_a;
  logic              obs_b;
  logic              term_a;
  logic              term_b;
  logic              stutter_a;
  logic              stutter_b;
  logic [SYNC_W-1:0] sync_count;
  logic              mismatch;
  logic              fault;
  logic              done;
  logic [STAT_W-1:0] stut_cnt_a;
  logic [STAT_W-1:0] stut_cnt_b;

  modport master (
    output obs_a, obs_b, term_a, term_b,
    input  stutter_a, stutter_b, sync_count,
    input  mismatch, fault, done,
    input  stut_cnt_a, stut_cnt_b
  );

  modport slave (
    input  obs_a, obs_b, term_a, term_b,
    output stutter_a, stutter_b, sync_count,
    output mismatch, fault, done,
    output stut_cnt_a, stut_cnt_b
  );
endinterface

// File: rtl/stutter_scheduler.sv
// Aligns observable steps of two stuttering copies (A, B), parks
// terminated copies, bounds consecutive stutter and flags misalignment.
// Ports: clk, reset (sync, active-high), bus (stutter_scheduler_if.slave:
//   obs_a/b, term_a/b in; stutter_a/b, sync_count, mismatch, fault,
//   done, stut_cnt_a/b out).
// Optional: define STUTTER_STATS_EN to enable stut_cnt_a/b counters;
//   otherwise both read 0.
module stutter_scheduler #(
  parameter int MAX_STUTTER = 7,
  parameter int SYNC_W      = 4,
  parameter int STAT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  stutter_scheduler_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_STUTTER + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STUTTER);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [RUN_W-1:0]  r_run_a;
  logic [RUN_W-1:0]  r_run_b;
  logic [SYNC_W-1:0] r_sync;
  logic              r_mismatch;
  logic              r_fault;
  logic              r_done;

  logic w_r1, w_r2a, w_r2b;
  logic w_r3, w_r4, w_r5, w_r6;
  logic w_live;

  logic w_sa, w_sb;
  logic w_inc_a, w_inc_b;
  logic w_mm_set, w_flt_set;
  logic w_sync_inc, w_to_done;

  // Mutually exclusive rule selects in priority order.
  assign w_live = ~bus.term_a & ~bus.term_b;
  assign w_r1   =  bus.term_a &  bus.term_b;
  assign w_r2a  =  bus.term_a & ~bus.term_b;
  assign w_r2b  = ~bus.term_a &  bus.term_b;
  assign w_r3   = w_live &  bus.obs_a &  bus.obs_b;
  assign w_r4   = w_live &  bus.obs_a & ~bus.obs_b;
  assign w_r5   = w_live & ~bus.obs_a &  bus.obs_b;
  assign w_r6   = w_live & ~bus.obs_a & ~bus.obs_b;

  always_comb begin
    w_sa       = 1'b1;
    w_sb       = 1'b1;
    w_inc_a    = 1'b0;
    w_inc_b    = 1'b0;
    w_mm_set   = 1'b0;
    w_flt_set  = 1'b0;
    w_sync_inc = 1'b0;
    w_to_done  = 1'b0;
    if (!reset && r_state == ST_RUN) begin
      unique case (1'b1)
        w_r1: begin
          w_to_done = 1'b1;
        end
        w_r2a: begin
          // Live copy B may not emit alone.
          w_sb     = bus.obs_b;
          w_mm_set = bus.obs_b;
        end
        w_r2b: begin
          w_sa     = bus.obs_a;
          w_mm_set = bus.obs_a;
        end
        w_r3: begin
          w_sa       = 1'b0;
          w_sb       = 1'b0;
          w_sync_inc = 1'b1;
        end
        w_r4: begin
          w_sb = 1'b0;
          // Bound reached: force A forward.
          if (r_run_a == RUN_MAX) begin
            w_sa      = 1'b0;
            w_flt_set = 1'b1;
          end else begin
            w_inc_a = 1'b1;
          end
        end
        w_r5: begin
          w_sa = 1'b0;
          if (r_run_b == RUN_MAX) begin
            w_sb      = 1'b0;
            w_flt_set = 1'b1;
          end else begin
            w_inc_b = 1'b1;
          end
        end
        w_r6: begin
          w_sa = 1'b0;
          w_sb = 1'b0;
        end
        default: begin
          w_sa = 1'b1;
          w_sb = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_run_a    <= '0;
      r_run_b    <= '0;
      r_sync     <= '0;
      r_mismatch <= 1'b0;
      r_fault    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_to_done) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
      end
      if (w_inc_a)
        r_run_a <= r_run_a + RUN_W'(1);
      else if (!w_sa)
        r_run_a <= '0;
      if (w_inc_b)
        r_run_b <= r_run_b + RUN_W'(1);
      else if (!w_sb)
        r_run_b <= '0;
      if (w_sync_inc && r_sync != '1)
        r_sync <= r_sync + SYNC_W'(1);
      if (w_mm_set)
        r_mismatch <= 1'b1;
      if (w_flt_set)
        r_fault <= 1'b1;
    end
  end

  assign bus.stutter_a  = w_sa;
  assign bus.stutter_b  = w_sb;
  assign bus.sync_count = r_sync;
  assign bus.mismatch   = r_mismatch;
  assign bus.fault      = r_fault;
  assign bus.done       = r_done;

`ifdef STUTTER_STATS_EN
  logic [STAT_W-1:0] r_cnt_a;
  logic [STAT_W-1:0] r_cnt_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_sa && r_cnt_a != '1)
        r_cnt_a <= r_cnt_a + STAT_W'(1);
      if (w_sb && r_cnt_b != '1)
        r_cnt_b <= r_cnt_b + STAT_W'(1);
    end
  end

  assign bus.stut_cnt_a = r_cnt_a;
  assign bus.stut_cnt_b = r_cnt_b;
`else
  assign bus.stut_cnt_a = '0;
  assign bus.stut_cnt_b = '0;
`endif

endmodule

// File: tb/tb_stutter_scheduler.sv
// Scoreboard bench for stutter_scheduler: directed scenarios then
// randomized segments, checked against a rule-level reference model.
module tb_stutter_scheduler;

  localparam int MAXS   = 7;
  localparam int SYNC_W = 4;
  localparam int STAT_W = 8;
  localparam int SYNC_SAT = (1 << SYNC_W) - 1;
  localparam int STAT_SAT = (1 << STAT_W) - 1;

  logic clk;
  logic reset;

  stutter_scheduler_if #(.SYNC_W(SYNC_W), .STAT_W(STAT_W)) bus ();

  stutter_scheduler #(
    .MAX_STUTTER(MAXS),
    .SYNC_W(SYNC_W),
    .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sa;
    bit sb;
    int sync;
    bit mm;
    bit flt;
    bit dn;
    int ca;
    int cb;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_done;
  bit m_mm;
  bit m_flt;
  int m_sync;
  int m_run[2];
  int m_cnt[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stutter_a", int'(bus.stutter_a), int'(e.sa));
      chk("stutter_b", int'(bus.stutter_b), int'(e.sb));
      chk("sync_count", int'(bus.sync_count), e.sync);
      chk("mismatch", int'(bus.mismatch), int'(e.mm));
      chk("fault", int'(bus.fault), int'(e.flt));
      chk("done", int'(bus.done), int'(e.dn));
      chk("stut_cnt_a", int'(bus.stut_cnt_a), e.ca);
      chk("stut_cnt_b", int'(bus.stut_cnt_b), e.cb);
    end
  end

  // One clock of stimulus: apply inputs, predict, push, advance.
  task automatic cyc(input bit r, input bit oa, input bit ob,
                     input bit ta, input bit tb);
    exp_t e;
    bit   st[2];
    bit   obs[2];
    bit   trm[2];
    int   k;
    reset      = r;
    bus.obs_a  = oa;
    bus.obs_b  = ob;
    bus.term_a = ta;
    bus.term_b = tb;
    obs[0] = oa; obs[1] = ob;
    trm[0] = ta; trm[1] = tb;
    st[0] = 1'b1; st[1] = 1'b1;
    // Registered outputs show pre-edge model state.
    e.sync = m_sync;
    e.mm   = m_mm;
    e.flt  = m_flt;
    e.dn   = m_done;
`ifdef STUTTER_STATS_EN
    e.ca = m_cnt[0];
    e.cb = m_cnt[1];
`else
    e.ca = 0;
    e.cb = 0;
`endif
    if (r) begin
      m_done = 0; m_mm = 0; m_flt = 0; m_sync = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (!m_done) begin
        if (ta && tb) begin
          m_done = 1;
        end else if (ta || tb) begin
          k = ta ? 1 : 0;
          st[k] = obs[k];
          if (obs[k]) m_mm = 1;
        end else if (oa && ob) begin
          st[0] = 0; st[1] = 0;
          if (m_sync < SYNC_SAT) m_sync++;
        end else if (oa || ob) begin
          k = oa ? 0 : 1;
          st[1-k] = 0;
          m_run[1-k] = 0;
          if (m_run[k] >= MAXS) begin
            st[k] = 0;
            m_flt = 1;
            m_run[k] = 0;
          end else begin
            m_run[k]++;
          end
        end else begin
          st[0] = 0; st[1] = 0;
        end
        for (int i = 0; i < 2; i++)
          if (!st[i]) m_run[i] = 0;
      end
      for (int i = 0; i < 2; i++)
        if (st[i] && m_cnt[i] < STAT_SAT) m_cnt[i]++;
    end
    if (trm[0] && obs[0] && trm[1]) k = 0;
    e.sa = st[0];
    e.sb = st[1];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit oa, ob, ta, tb;
    int len;
    m_done = 0; m_mm = 0; m_flt = 0; m_sync = 0;
    m_run[0] = 0; m_run[1] = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    reset = 1'b1;
    bus.obs_a = 0; bus.obs_b = 0;
    bus.term_a = 0; bus.term_b = 0;
    @(posedge clk);
    #1;
    // Reset held, then idle
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Alignment: A waits for B
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Fairness bound
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Mismatch: B terminated while A observable
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // Termination then DONE hold
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Random held segments
    for (int s = 0; s < 400; s++) begin
      oa  = 1'($urandom_range(0, 1));
      ob  = 1'($urandom_range(0, 1));
      ta  = ($urandom_range(0, 11) == 0);
      tb  = ($urandom_range(0, 11) == 0);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) cyc(1, oa, ob, ta, tb);
      for (int j = 0; j < len; j++) cyc(0, oa, ob, ta, tb);
    end
    begin
      int waited = 0;
      while (q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (q.size() > 0) begin
        n_errors++;
        $display("FAIL drain: got %0d pending expected 0", q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
